// File: rtl/exc_commit.sv
// Commit-stage exception arbiter: prioritises raw exception flags and interrupts, issues
// registered single-cycle commands to the CSR unit, and sequences RUN/IDLE/FLUSH. TLB-class exceptions need EXC_TLB_EN.
module exc_commit (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic [14:0] wb_exc,
    input  logic        wb_is_ertn,
    input  logic        wb_is_idle,
    input  logic        wb_refetch,
    input  logic        csr_ie,
    input  logic [11:0] csr_lie,
    input  logic [11:0] csr_is,
    input  logic        csr_exlike,
    output logic        is_exc,
    output logic        is_ertn,
    output logic        is_fetch_again,
    output logic        is_idle,
    output logic [5:0]  excode,
    output logic [8:0]  esubcode,
    output logic [31:0] badvaddr,
    output logic [31:0] csr_pc,
    output logic        flush
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

`ifdef EXC_TLB_EN
    localparam logic [14:0] EXC_MASK = 15'h7FFF;
`else
    localparam logic [14:0] EXC_MASK = 15'h03F1;
`endif

    // Flag bit order equals priority order, so the lowest set bit wins.
    function automatic logic [3:0] first_set(input logic [14:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Returns {addr_sel[1:0], excode[5:0]}; addr_sel 1 = wb_pc, 2 = wb_vaddr, 0 = zero.
    function automatic logic [7:0] exc_info(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = {2'd1, 6'h08};
            4'd1:    r = {2'd1, 6'h3F};
            4'd2:    r = {2'd1, 6'h03};
            4'd3:    r = {2'd1, 6'h07};
            4'd4:    r = {2'd0, 6'h0D};
            4'd5:    r = {2'd0, 6'h0E};
            4'd6:    r = {2'd0, 6'h0B};
            4'd7:    r = {2'd0, 6'h0C};
            4'd8:    r = {2'd2, 6'h08};
            4'd9:    r = {2'd2, 6'h09};
            4'd10:   r = {2'd2, 6'h3F};
            4'd11:   r = {2'd2, 6'h01};
            4'd12:   r = {2'd2, 6'h02};
            4'd13:   r = {2'd2, 6'h07};
            4'd14:   r = {2'd2, 6'h04};
            default: r = {2'd0, 6'h00};
        endcase
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        ready_q, ready_d;
    logic        is_exc_q, is_exc_d, is_ertn_q, is_ertn_d;
    logic        is_fetch_again_q, is_fetch_again_d, is_idle_q, is_idle_d;
    logic        flush_q, flush_d;
    logic [5:0]  excode_q, excode_d;
    logic [8:0]  esubcode_q, esubcode_d;
    logic [31:0] badvaddr_q, badvaddr_d, csr_pc_q, csr_pc_d;
    logic        int_pend_s;
    logic [14:0] exc_flags_s;
    logic [7:0]  exc_info_s;

    // Next-state and command decode.
    always_comb begin
        int_pend_s       = csr_ie & (|(csr_lie & csr_is));
        exc_flags_s      = wb_exc & EXC_MASK;
        exc_info_s       = exc_info(first_set(exc_flags_s));
        state_d          = state_q;
        is_exc_d         = 1'b0;
        is_ertn_d        = 1'b0;
        is_fetch_again_d = 1'b0;
        is_idle_d        = 1'b0;
        excode_d         = excode_q;
        esubcode_d       = esubcode_q;
        badvaddr_d       = badvaddr_q;
        csr_pc_d         = csr_pc_q;
        case (state_q)
            ST_RUN: begin
                if (wb_valid) begin
                    if (int_pend_s || (|exc_flags_s)) begin
                        is_exc_d = 1'b1;
                        csr_pc_d = wb_pc;
                        state_d  = ST_FLUSH;
                        if (int_pend_s) begin
                            excode_d   = 6'h00;
                            esubcode_d = 9'd0;
                            badvaddr_d = 32'd0;
                        end else begin
                            excode_d   = exc_info_s[5:0];
                            esubcode_d = (first_set(exc_flags_s) == 4'd8) ? 9'd1 : 9'd0;
                            case (exc_info_s[7:6])
                                2'd1:    badvaddr_d = wb_pc;
                                2'd2:    badvaddr_d = wb_vaddr;
                                default: badvaddr_d = 32'd0;
                            endcase
                        end
                    end else if (wb_is_ertn || wb_refetch) begin
                        is_ertn_d        = wb_is_ertn;
                        is_fetch_again_d = wb_refetch;
                        state_d          = ST_FLUSH;
                    end else if (wb_is_idle) begin
                        is_idle_d = 1'b1;
                        csr_pc_d  = wb_pc;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_IDLE: begin
                // csr_pc still holds the IDLE instruction's PC from the is_idle command.
                if (int_pend_s) begin
                    is_exc_d   = 1'b1;
                    excode_d   = 6'h00;
                    esubcode_d = 9'd0;
                    badvaddr_d = 32'd0;
                    state_d    = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (csr_exlike) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_RUN;
        endcase
        flush_d = (state_d == ST_FLUSH);
        ready_d = (state_d == ST_RUN);
    end

    // State and registered command outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            ready_q          <= 1'b1;
            is_exc_q         <= 1'b0;
            is_ertn_q        <= 1'b0;
            is_fetch_again_q <= 1'b0;
            is_idle_q        <= 1'b0;
            flush_q          <= 1'b0;
            excode_q         <= 6'd0;
            esubcode_q       <= 9'd0;
            badvaddr_q       <= 32'd0;
            csr_pc_q         <= 32'd0;
        end else begin
            state_q          <= state_d;
            ready_q          <= ready_d;
            is_exc_q         <= is_exc_d;
            is_ertn_q        <= is_ertn_d;
            is_fetch_again_q <= is_fetch_again_d;
            is_idle_q        <= is_idle_d;
            flush_q          <= flush_d;
            excode_q         <= excode_d;
            esubcode_q       <= esubcode_d;
            badvaddr_q       <= badvaddr_d;
            csr_pc_q         <= csr_pc_d;
        end
    end

    assign wb_ready       = ready_q;
    assign is_exc         = is_exc_q;
    assign is_ertn        = is_ertn_q;
    assign is_fetch_again = is_fetch_again_q;
    assign is_idle        = is_idle_q;
    assign flush          = flush_q;
    assign excode         = excode_q;
    assign esubcode       = esubcode_q;
    assign badvaddr       = badvaddr_q;
    assign csr_pc         = csr_pc_q;

endmodule

// File: tb/tb_exc_commit.sv
// Randomized bench for exc_commit against a table-driven behavioural model, plus directed scenarios.
module tb_exc_commit;

    logic        clk = 1'b0;
    logic        reset, wb_valid, wb_ready;
    logic [31:0] wb_pc, wb_vaddr;
    logic [14:0] wb_exc;
    logic        wb_is_ertn, wb_is_idle, wb_refetch, csr_ie, csr_exlike;
    logic [11:0] csr_lie, csr_is;
    logic        is_exc, is_ertn, is_fetch_again, is_idle, flush;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr, csr_pc;

    exc_commit dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_exc(wb_exc),
        .wb_is_ertn(wb_is_ertn), .wb_is_idle(wb_is_idle), .wb_refetch(wb_refetch),
        .csr_ie(csr_ie), .csr_lie(csr_lie), .csr_is(csr_is), .csr_exlike(csr_exlike),
        .is_exc(is_exc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again), .is_idle(is_idle),
        .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr), .csr_pc(csr_pc),
        .flush(flush)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Priority-ordered exception table: flag bit i, its code and where badvaddr comes from.
    int unsigned code_tab [15] = '{8, 63, 3, 7, 13, 14, 11, 12, 8, 9, 63, 1, 2, 7, 4};
    int unsigned addr_tab [15] = '{1, 1, 1, 1, 0, 0, 0, 0, 2, 2, 2, 2, 2, 2, 2};
    logic [14:0] tlb_only = 15'h7C0E;

    // Model state: 0 = running, 1 = idle-waiting, 2 = flushing.
    int          m_mode = 0;
    logic        m_exc, m_ertn, m_fa, m_idle, m_flush, m_ready;
    logic [5:0]  m_code;
    logic [8:0]  m_sub;
    logic [31:0] m_bad, m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit flag_enabled(input int i);
`ifdef EXC_TLB_EN
        return 1'b1;
`else
        return !tlb_only[i];
`endif
    endfunction

    task automatic model_next();
        bit ip, found;
        ip = csr_ie && ((csr_lie & csr_is) != 12'd0);
        {m_exc, m_ertn, m_fa, m_idle} = 4'b0000;
        if (reset) begin
            m_mode = 0;
            m_code = 6'd0; m_sub = 9'd0; m_bad = 32'd0; m_pc = 32'd0;
        end else if (m_mode == 0) begin
            if (wb_valid) begin
                found = ip;
                if (ip) begin
                    m_code = 6'd0; m_sub = 9'd0; m_bad = 32'd0;
                end
                for (int i = 0; i < 15; i++) begin
                    if (!found && wb_exc[i] && flag_enabled(i)) begin
                        found  = 1'b1;
                        m_code = 6'(code_tab[i]);
                        m_sub  = (i == 8) ? 9'd1 : 9'd0;
                        m_bad  = (addr_tab[i] == 1) ? wb_pc : (addr_tab[i] == 2) ? wb_vaddr : 32'd0;
                    end
                end
                if (found) begin
                    m_exc = 1'b1; m_pc = wb_pc; m_mode = 2;
                end else if (wb_is_ertn || wb_refetch) begin
                    m_ertn = wb_is_ertn; m_fa = wb_refetch; m_mode = 2;
                end else if (wb_is_idle) begin
                    m_idle = 1'b1; m_pc = wb_pc; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (ip) begin
                m_exc = 1'b1; m_code = 6'd0; m_sub = 9'd0; m_bad = 32'd0; m_mode = 2;
            end
        end else begin
            if (csr_exlike) m_mode = 0;
        end
        m_flush = (m_mode == 2);
        m_ready = (m_mode == 0);
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        check("wb_ready", 32'(wb_ready), 32'(m_ready));
        check("is_exc", 32'(is_exc), 32'(m_exc));
        check("is_ertn", 32'(is_ertn), 32'(m_ertn));
        check("is_fetch_again", 32'(is_fetch_again), 32'(m_fa));
        check("is_idle", 32'(is_idle), 32'(m_idle));
        check("flush", 32'(flush), 32'(m_flush));
        check("excode", 32'(excode), 32'(m_code));
        check("esubcode", 32'(esubcode), 32'(m_sub));
        check("badvaddr", badvaddr, m_bad);
        check("csr_pc", csr_pc, m_pc);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; wb_valid = 1'b0; wb_exc = 15'd0;
        wb_is_ertn = 1'b0; wb_is_idle = 1'b0; wb_refetch = 1'b0;
        csr_ie = 1'b0; csr_lie = 12'd0; csr_is = 12'd0; csr_exlike = 1'b0;
    endtask

    initial begin
        idle_inputs();
        wb_pc = 32'd0; wb_vaddr = 32'd0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // ALE with a fixed PC/vaddr, then release with csr_exlike.
        wb_valid = 1'b1; wb_exc = 15'h0200; wb_pc = 32'h1C000100; wb_vaddr = 32'h00000003;
        step();
        check("ale_excode", 32'(excode), 32'h09);
        check("ale_badvaddr", badvaddr, 32'h00000003);
        check("ale_flush", 32'(flush), 32'd1);
        idle_inputs(); wb_valid = 1'b1; csr_exlike = 1'b1;
        step();
        idle_inputs();
        step();
        check("ale_ready", 32'(wb_ready), 32'd1);

        // Interrupt beats ADEF and ALE.
        wb_valid = 1'b1; wb_exc = 15'h0201; csr_ie = 1'b1; csr_lie = 12'h001; csr_is = 12'h001;
        step();
        check("int_excode", 32'(excode), 32'h00);
        check("int_badvaddr", badvaddr, 32'd0);
        check("int_csr_pc", csr_pc, 32'h1C000100);
        idle_inputs(); csr_exlike = 1'b1;
        step();
        idle_inputs();

        // IDLE, wake by interrupt on line 11 after ten cycles.
        wb_valid = 1'b1; wb_is_idle = 1'b1; wb_pc = 32'h1C000200;
        step();
        check("idle_pulse", 32'(is_idle), 32'd1);
        check("idle_ready", 32'(wb_ready), 32'd0);
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        csr_ie = 1'b1; csr_lie = 12'h800; csr_is = 12'h800;
        step();
        check("wake_exc", 32'(is_exc), 32'd1);
        check("wake_pc", csr_pc, 32'h1C000200);
        idle_inputs(); csr_exlike = 1'b1;
        step();
        idle_inputs();

        // TLBR_M: only reported when TLB exceptions are built in.
        wb_valid = 1'b1; wb_exc = 15'h0400; wb_vaddr = 32'h80001000;
        step();
`ifdef EXC_TLB_EN
        check("tlbr_excode", 32'(excode), 32'h3F);
        check("tlbr_badvaddr", badvaddr, 32'h80001000);
`else
        check("tlbr_ignored", 32'(is_exc), 32'd0);
`endif
        idle_inputs(); csr_exlike = 1'b1;
        step();
        idle_inputs();

        // Refetch, then reset while flushing.
        wb_valid = 1'b1; wb_refetch = 1'b1;
        step();
        check("refetch_pulse", 32'(is_fetch_again), 32'd1);
        idle_inputs(); step();
        reset = 1'b1; step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_flush", 32'(flush), 32'd0);
            check("post_reset_fa", 32'(is_fetch_again), 32'd0);
        end

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            reset      = ($urandom_range(0, 99) == 0);
            wb_valid   = ($urandom_range(0, 3) != 0);
            wb_pc      = $urandom;
            wb_vaddr   = $urandom;
            wb_exc     = 15'd0;
            if ($urandom_range(0, 1) == 1) wb_exc[$urandom_range(0, 14)] = 1'b1;
            if ($urandom_range(0, 3) == 0) wb_exc[$urandom_range(0, 14)] = 1'b1;
            sel        = $urandom_range(0, 5);
            wb_is_ertn = (sel == 1);
            wb_is_idle = (sel == 2);
            wb_refetch = (sel == 3);
            csr_ie     = ($urandom_range(0, 2) == 0);
            csr_lie    = 12'($urandom);
            csr_is     = ($urandom_range(0, 3) == 0) ? (12'd1 << $urandom_range(0, 11)) : 12'd0;
            csr_exlike = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 wb_valid  in  1  commit-stage instruction present; consumed only when wb_ready=1.
REQ-004 wb_ready  out  1  commit stage may advance.
REQ-005 wb_pc  in  32  PC of committing instruction.
REQ-006 wb_vaddr  in  32  memory-access virtual address.
REQ-007 wb_exc  in  15  raw flags: [0]ADEF [1]TLBR_F [2]PIF [3]PPI_F [4]INE [5]IPE [6]SYS [7]BRK [8]ADEM [9]ALE [10]TLBR_M [11]PIL [12]PIS [13]PPI_M [14]PME.
REQ-008 wb_is_ertn, wb_is_idle, wb_refetch  in  1 each  ERTN / IDLE / refetch-after (TLB op, CSR write) markers.
REQ-009 csr_ie  in  1; csr_lie  in  12; csr_is  in  12  interrupt enable, local enables, pending status.
REQ-010 csr_exlike  in  1  redirect-taken pulse from CSR unit.
REQ-011 is_exc, is_ertn, is_fetch_again, is_idle  out  1 each  single-cycle commands to CSR unit.
REQ-012 excode  out  6; esubcode  out  9; badvaddr  out  32; csr_pc  out  32  exception record, valid with is_exc.
REQ-013 flush  out  1  kill all younger pipeline stages.

Function
REQ-014 int_pend SHALL equal csr_ie & |(csr_lie & csr_is), evaluated every cycle.
REQ-015 FSM states SHALL be RUN, IDLE, FLUSH; wb_ready=1 only in RUN.
REQ-016 RUN, accepted wb_valid: priority INT(int_pend) > ADEF > TLBR_F > PIF > PPI_F > INE > IPE > SYS > BRK > ADEM > ALE > TLBR_M > PIL > PIS > PPI_M > PME; highest SHALL win, others discarded.
REQ-017 excode/esubcode: INT 0x00/0; PIL 0x01; PIS 0x02; PIF 0x03; PME 0x04; PPI_F/PPI_M 0x07; ADEF 0x08/0; ADEM 0x08/1; ALE 0x09; SYS 0x0B; BRK 0x0C; INE 0x0D; IPE 0x0E; TLBR_F/TLBR_M 0x3F; esubcode 0 except ADEM.
REQ-018 badvaddr SHALL be wb_pc for ADEF/TLBR_F/PIF/PPI_F, wb_vaddr for ADEM/ALE/TLBR_M/PIL/PIS/PPI_M/PME, 0 otherwise; csr_pc SHALL be wb_pc.
REQ-019 Any exception (incl. INT) SHALL suppress ERTN/IDLE/refetch markers of that instruction.
REQ-020 No exception, wb_is_ertn: pulse is_ertn; wb_refetch: pulse is_fetch_again; both then enter FLUSH.
REQ-021 No exception, wb_is_idle: pulse is_idle with csr_pc=wb_pc, enter IDLE, no flush.
REQ-022 IDLE: hold until int_pend=1, then pulse is_exc excode 0x00, csr_pc=idle PC, enter FLUSH.
REQ-023 All command outputs SHALL be registered, asserted exactly one cycle after acceptance, high for one cycle.
REQ-024 flush SHALL assert the cycle a command (except is_idle) is issued and remain high through FLUSH.
REQ-025 FLUSH SHALL return to RUN on the cycle after csr_exlike=1; wb_valid ignored meanwhile.
REQ-026 Normal instruction, no exception, no marker: no output pulse, FSM stays RUN.
REQ-027 int_pend rising while FLUSH SHALL be deferred to the next accepted instruction in RUN.

Reset
REQ-028 Reset SHALL force state RUN; is_exc, is_ertn, is_fetch_again, is_idle, flush=0; excode, esubcode, badvaddr, csr_pc=0; wb_ready=1 from first post-reset cycle.
REQ-029 Reset mid-FLUSH or mid-IDLE SHALL abandon the operation with no further pulse.

Configuration
REQ-030 Macro EXC_TLB_EN defined: TLBR_F, PIF, PPI_F, TLBR_M, PIL, PIS, PPI_M, PME handled per REQ-016..018.
REQ-031 EXC_TLB_EN undefined: wb_exc bits 1,2,3,10-14 SHALL be ignored (treated 0); remaining priority order unchanged.

Verification
REQ-032 wb_exc[9]=1, wb_pc=0x1C000100, wb_vaddr=0x00000003 -> next cycle is_exc=1, excode=0x09, badvaddr=0x00000003, flush=1; RUN after csr_exlike.
REQ-033 wb_exc[0] and [9] set, int_pend=1 -> excode=0x00, badvaddr=0, csr_pc=wb_pc.
REQ-034 wb_is_idle, pc=0x1C000200 -> is_idle pulse, wb_ready=0; csr_is[11]=csr_lie[11]=csr_ie=1 after 10 cycles -> is_exc excode 0x00, csr_pc=0x1C000200.
REQ-035 wb_exc[10]=1, wb_vaddr=0x80001000: EXC_TLB_EN defined -> excode 0x3F, badvaddr=0x80001000; undefined -> no pulse.
REQ-036 wb_refetch then reset asserted in FLUSH -> flush=0, wb_ready=1 after reset, no is_fetch_again repeat.
